// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, legal store
// byte-enable patterns and the default memory depth.
package dm_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 3072;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmState_t;

  // Store lane patterns: full word, aligned halves, single bytes.
  localparam logic [3:0] BeWord   = 4'b1111;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeByte0  = 4'b0001;
  localparam logic [3:0] BeByte1  = 4'b0010;
  localparam logic [3:0] BeByte2  = 4'b0100;
  localparam logic [3:0] BeByte3  = 4'b1000;

  function automatic logic be_legal(input logic [3:0] be);
    return be inside {BeWord, BeHalfLo, BeHalfHi, BeByte0, BeByte1, BeByte2, BeByte3};
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// M-stage load/store handshake between the pipeline (master) and the data
// memory responder (slave).
interface dm_responder_if;
  logic        Req;
  logic        ReqWe;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [3:0]  ReqByteEn;
  logic        Busy;
  logic        Ack;
  logic [31:0] RData;
  logic        Err;

  modport master (
    output Req, ReqWe, ReqAddr, ReqWData, ReqByteEn,
    input  Busy, Ack, RData, Err
  );

  modport slave (
    input  Req, ReqWe, ReqAddr, ReqWData, ReqByteEn,
    output Busy, Ack, RData, Err
  );
endinterface

// File: rtl/dm_word_ram.sv
// Word array with per-byte-lane synchronous write, combinational read and a
// full clear while Reset is low.
module dm_word_ram #(
  parameter int unsigned Depth = 3072,
  parameter int unsigned AddrW = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       WrEn,
  input  logic [AddrW-1:0] Addr,
  input  logic [31:0]      WrData,
  output logic [31:0]      RdData
);

  logic [31:0] mem [Depth];
  logic        addrOk;

  assign addrOk = 32'(Addr) < Depth;

  // Clear every word on reset, otherwise merge the enabled lanes into the word.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i[AddrW-1:0]] <= '0;
      end
    end else if (addrOk) begin
      for (int l = 0; l < 4; l++) begin
        if (WrEn[l]) begin
          mem[Addr][8*l +: 8] <= WrData[8*l +: 8];
        end
      end
    end
  end

  assign RdData = addrOk ? mem[Addr] : '0;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one request at a time, waits WAIT_CYCLES,
// then answers with a single-cycle Ack carrying load data or an error flag.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           Clk,
  input logic           Reset,
  dm_responder_if.slave bus
);

  localparam int unsigned AddrW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WaitInit  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmState_t    state;
  logic [3:0]  count;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capWData;
  logic [3:0]  capByteEn;

  logic        inResp;
  logic        errNow;
  logic [3:0]  wrEn;
  logic [31:0] ramRData;

  // Request FSM; all request fields are frozen at acceptance.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= StIdle;
      count     <= '0;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capWData  <= '0;
      capByteEn <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.Req) begin
            capWe     <= bus.ReqWe;
            capAddr   <= bus.ReqAddr;
            capWData  <= bus.ReqWData;
            capByteEn <= bus.ReqByteEn;
            if (WAIT_CYCLES > 0) begin
              state <= StWait;
              count <= WaitInit;
            end else begin
              state <= StResp;
            end
          end
        end
        StWait: begin
          if (count == 4'd0) begin
            state <= StResp;
          end else begin
            count <= count - 4'd1;
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Error: address past the array, or a store with an unsupported lane mask.
  always_comb begin
    inResp = (state == StResp);
    errNow = (capAddr >= AddrLimit) || (capWe && !be_legal(capByteEn));
    wrEn   = (inResp && capWe && !errNow) ? capByteEn : 4'b0000;
  end

  dm_word_ram #(
    .Depth (DEPTH_WORDS),
    .AddrW (AddrW)
  ) uRam (
    .Clk    (Clk),
    .Reset  (Reset),
    .WrEn   (wrEn),
    .Addr   (capAddr[AddrW+1:2]),
    .WrData (capWData),
    .RdData (ramRData)
  );

  assign bus.Busy  = (state != StIdle);
  assign bus.Ack   = inResp;
  assign bus.Err   = inResp && errNow;
  assign bus.RData = (inResp && !capWe && !errNow) ? ramRData : '0;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the target end of the pipeline's M-stage load/store interface.
- Accepts one word-addressed request at a time with byte-lane enables, inserts a configurable wait-state latency, and answers with a single-cycle Ack carrying read data or an error flag.
- Replaces the zero-latency data memory so the pipeline's stall logic can be exercised against a multi-cycle memory.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; valid byte addresses are 0x0000 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between acceptance and Ack; legal range 0..15.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low; Reset==0 at a rising edge resets the block.
- Req  input  1  request valid; sampled only when the block is idle.
- ReqWe  input  1  1 = store, 0 = load.
- ReqAddr  input  32  byte address; bits [1:0] are ignored for word selection.
- ReqWData  input  32  store data, already lane-aligned by the requester.
- ReqByteEn  input  4  byte-lane enables for stores; ignored for loads.
- Busy  output  1  high when the state is not IDLE.
- Ack  output  1  one-cycle response strobe.
- RData  output  32  full addressed word during a load Ack; 0 otherwise.
- Err  output  1  valid only with Ack; out-of-range address or illegal byte-enable pattern.

Behaviour:
- Reset: state=IDLE, counter=0, Busy=0, Ack=0, Err=0, RData=0, and every memory word cleared to 0.
- Reset mid-operation aborts the access: no write commits and no Ack is issued.
- States:
  - IDLE: if Req, capture We/Addr/WData/ByteEn into internal registers. Go to WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0, otherwise go straight to RESP.
  - WAIT: decrement the counter each cycle; move to RESP in the cycle after the counter reaches 0.
  - RESP: Ack=1 for exactly this cycle; next state is IDLE.
- Latency: Ack is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: Req is ignored while Busy, including during the RESP cycle. Back-to-back requests therefore have one idle cycle between an Ack and the next acceptance. The requester must hold Req until Busy rises.
- All request fields are captured at acceptance; later changes on the input pins have no effect on the access in flight.
- Legal store byte enables: 1111, 0011, 1100, 0001, 0010, 0100, 1000.
  - Any other pattern, including 0000, gives Err=1 and no write.
- Range check: ReqAddr >= 4*DEPTH_WORDS gives Err=1, RData=0, and no write.
- Store commit: the write happens on the RESP edge, updating only the enabled lanes of word ReqAddr[31:2].
- Load data: RData is the word as it stands in the RESP cycle. A load accepted after a store's Ack returns the new data.
- Ack outside RESP is 0; Err and RData are 0 whenever Ack=0.

Decomposition:
- Shared package dm_pkg holds:
  - the state encoding (IDLE, WAIT, RESP; 2 bits);
  - the legal byte-enable constants;
  - a be_legal function;
  - the DEPTH_WORDS default.
- One sub-module, dm_word_ram: a synchronous-write, combinational-read word array with a 4-lane write enable and clear-on-reset.
- FSM, counter, capture registers and error checks live in dm_responder.

Test Plan:
- Reset, then WAIT_CYCLES=2, store Addr=0x10, WData=0x12345678, ByteEn=1111 accepted at cycle 0 -> Busy=1 at cycles 1-3, Ack=1 and Err=0 at cycle 3, Ack=0 at cycle 4.
- Then load Addr=0x10 -> Ack after 3 cycles with RData=0x12345678.
- Store ByteEn=0100, WData=0x00AB0000 to 0x10, then load 0x10 -> RData=0x12AB5678.
- Store ByteEn=0101 to 0x10 -> Ack with Err=1, and a following load of 0x10 is unchanged. Load Addr=0x3000 -> Ack with Err=1 and RData=0.
- WAIT_CYCLES=0, two requests with Req held continuously -> Ack one cycle after each acceptance, with one idle cycle between Ack and the next acceptance.
- Change ReqAddr and ReqWData during WAIT -> the original captured values are written.
- Reset=0 during WAIT -> no Ack, no write, and all outputs at reset values on the next cycle.
